alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Initiator side of the ALU/accumulator datapath. Holds a small loadable program of ALU operations and issues them one at a time onto the ALU operand/mode inputs (A, B, Cin, Mode). After each issue it waits for the accumulator to register the result, then reads back Y/CBF. The captured Y can serve as the A operand of the next step, giving multi-step arithmetic chains without a bench driving the ALU directly.

Parameters:
WIDTH, 4, ALU operand/result width
MODE_W, 4, ALU mode field width
DEPTH, 8, program entries (power of two)
WAIT_CYC, 1, cycles between issue and accumulator result valid (1..15)
CNT_W, 4, width of the saturating CBF counter

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
prog_we  in  1  program write strobe
prog_addr  in  log2(DEPTH)  program write address
prog_data  in  MODE_W+WIDTH+3  instruction word {last, use_acc, cin, b[WIDTH-1:0], mode[MODE_W-1:0]}
Seed  in  WIDTH  initial A operand, sampled at Start
Start  in  1  run request, one-cycle pulse
acc_Y  in  WIDTH  accumulator result
acc_CBF  in  1  accumulator carry/borrow flag
alu_A  out  WIDTH  ALU operand A
alu_B  out  WIDTH  ALU operand B
alu_Cin  out  1  ALU carry in
alu_Mode  out  MODE_W  ALU mode select
Busy  out  1  high from the cycle after Start until Done
Done  out  1  one-cycle pulse at program end
result  out  WIDTH  last captured acc_Y
result_cbf  out  1  last captured acc_CBF
cbf_count  out  CNT_W  count of steps with CBF=1, saturating
step_count  out  log2(DEPTH)+1  steps completed in current/last run

Behaviour:
- Reset (async) clears state to IDLE and clears pc, acc_reg, all outputs (alu_*, Busy, Done, result, result_cbf, cbf_count, step_count) to 0. Program memory is not reset.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - prog_we writes prog_data to mem[prog_addr].
  - On Start: acc_reg<=Seed, pc<=0, cbf_count<=0, step_count<=0, Busy<=1, go to ISSUE.
- ISSUE, 1 cycle:
  - alu_A<=(use_acc ? acc_reg : Seed)
  - alu_B<=b, alu_Cin<=cin, alu_Mode<=mode, all from mem[pc].
  - Go to WAIT.
- WAIT: hold alu_* for WAIT_CYC cycles using a down counter, then go to CAPTURE.
- CAPTURE, 1 cycle:
  - result<=acc_Y, result_cbf<=acc_CBF, acc_reg<=acc_Y.
  - cbf_count increments when acc_CBF=1, saturating at 2^CNT_W-1.
  - step_count increments.
  - If last=1 or pc=DEPTH-1, go to DONE. Otherwise pc<=pc+1 and go to ISSUE.
- DONE, 1 cycle: Done=1, Busy<=0, pc<=0 (wrap), go to IDLE. alu_* hold their last values.
- Per-step cost is WAIT_CYC+2 cycles. Done asserts N*(WAIT_CYC+2)+1 cycles after the Start edge, where N is the number of steps executed.
- Start outside IDLE is ignored. prog_we outside IDLE is ignored, and memory is unchanged.
- Start and prog_we together in IDLE: the write completes, and the run starts using the new contents.
- Reset asserted mid-run aborts immediately (async) to IDLE with cleared outputs and no Done pulse.

Decomposition:
- Shared package holds:
  - state encoding enum {IDLE, ISSUE, WAIT, CAPTURE, DONE}
  - instruction field offsets (MODE_LSB, B_LSB, CIN_BIT, USE_ACC_BIT, LAST_BIT)
  - default WIDTH/MODE_W
- One natural sub-module: op_prog_mem, a DEPTH x (MODE_W+WIDTH+3) register file with synchronous write and asynchronous read, no reset.

Test Plan:
Bench uses an accumulator stub with WAIT_CYC=1: on each clock edge it registers {acc_CBF, acc_Y} = alu_A + alu_B + alu_Cin when mode=0.
- Two-step chain: Seed=3, prog0={0,0,0,4,0}, prog1={1,1,1,2,0}, Start -> alu_A=3,B=4 then A=7,B=2,Cin=1; result=4'hA, result_cbf=0, cbf_count=0, step_count=2, Done 7 cycles after Start.
- Overflow: Seed=F, prog0={1,0,1,F,0} -> result=F, result_cbf=1, cbf_count=1, step_count=1.
- No last bit in all 8 entries (b=1, use_acc=1, Seed=0) -> 8 steps, result=8, step_count=8, Done at cycle 25, pc wraps to 0.
- Start pulsed and prog_we to addr 0 with new data during step 0's WAIT -> Start ignored, memory unchanged, run completes once with the original result.
- Reset asserted during WAIT of step 1 -> same cycle: Busy=0, alu_*=0, result=0, step_count=0; no Done pulse. A later Start reruns the unchanged program correctly.
- Saturation, CNT_W=2: four overflowing steps -> cbf_count=3.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared states, instruction layout and defaults for the op sequencer
package alu_op_sequencer_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_MODE_W = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Instruction word is {last, use_acc, cin, b, mode}, mode in the low bits.
    localparam int MODE_LSB    = 0;
    localparam int B_LSB       = DEF_MODE_W;
    localparam int CIN_BIT     = DEF_MODE_W + DEF_WIDTH;
    localparam int USE_ACC_BIT = CIN_BIT + 1;
    localparam int LAST_BIT    = CIN_BIT + 2;

    function automatic int instr_b_lsb(input int mode_w);
        return MODE_LSB + mode_w;
    endfunction

    function automatic int instr_cin_bit(input int mode_w, input int width);
        return MODE_LSB + mode_w + width;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_op_prog_mem.sv
// rtl/alu_op_sequencer_op_prog_mem.sv - program register file, synchronous write, asynchronous read
module op_prog_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues a stored ALU program step by step and captures accumulator results
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODE_W   = DEF_MODE_W,
    parameter int DEPTH    = 8,
    parameter int WAIT_CYC = 1,
    parameter int CNT_W    = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          prog_we,
    input  logic [$clog2(DEPTH)-1:0]      prog_addr,
    input  logic [MODE_W+WIDTH+2:0]       prog_data,
    input  logic [WIDTH-1:0]              Seed,
    input  logic                          Start,
    input  logic [WIDTH-1:0]              acc_Y,
    input  logic                          acc_CBF,
    output logic [WIDTH-1:0]              alu_A,
    output logic [WIDTH-1:0]              alu_B,
    output logic                          alu_Cin,
    output logic [MODE_W-1:0]             alu_Mode,
    output logic                          Busy,
    output logic                          Done,
    output logic [WIDTH-1:0]              result,
    output logic                          result_cbf,
    output logic [CNT_W-1:0]              cbf_count,
    output logic [$clog2(DEPTH):0]        step_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int IW      = MODE_W + WIDTH + 3;
    localparam int B_LO    = instr_b_lsb(MODE_W);
    localparam int CIN_B   = instr_cin_bit(MODE_W, WIDTH);
    localparam int USE_B   = CIN_B + 1;
    localparam int LAST_B  = CIN_B + 2;
    localparam logic [AW-1:0]    PC_MAX    = AW'(DEPTH - 1);
    localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [2:0]          state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [3:0]          wait_q, wait_d;
    logic [WIDTH-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic                alu_cin_q, alu_cin_d;
    logic [MODE_W-1:0]   alu_mode_q, alu_mode_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                result_cbf_q, result_cbf_d;
    logic [CNT_W-1:0]    cbf_cnt_q, cbf_cnt_d;
    logic [AW:0]         step_q, step_d;
    logic [IW-1:0]       instr;
    logic                mem_we;

    // Writes only land while idle so a running program cannot be altered under it.
    assign mem_we = prog_we && (state_q == ST_IDLE);

    op_prog_mem #(.DEPTH(DEPTH), .AW(AW), .DW(IW)) u_mem (
        .clk   (Clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (instr)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        acc_d        = acc_q;
        wait_d       = wait_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cin_d    = alu_cin_q;
        alu_mode_d   = alu_mode_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        result_d     = result_q;
        result_cbf_d = result_cbf_q;
        cbf_cnt_d    = cbf_cnt_q;
        step_d       = step_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    acc_d     = Seed;
                    pc_d      = '0;
                    cbf_cnt_d = '0;
                    step_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_a_d    = instr[USE_B] ? acc_q : Seed;
                alu_b_d    = instr[B_LO +: WIDTH];
                alu_cin_d  = instr[CIN_B];
                alu_mode_d = instr[MODE_LSB +: MODE_W];
                wait_d     = WAIT_INIT;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q <= 4'd1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                result_d     = acc_Y;
                result_cbf_d = acc_CBF;
                acc_d        = acc_Y;
                if (acc_CBF && (cbf_cnt_q != CNT_MAX)) begin
                    cbf_cnt_d = cbf_cnt_q + 1'b1;
                end
                step_d = step_q + 1'b1;
                if (instr[LAST_B] || (pc_q == PC_MAX)) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pc_d    = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            acc_q        <= '0;
            wait_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_mode_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            result_cbf_q <= 1'b0;
            cbf_cnt_q    <= '0;
            step_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            acc_q        <= acc_d;
            wait_q       <= wait_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cin_q    <= alu_cin_d;
            alu_mode_q   <= alu_mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            result_cbf_q <= result_cbf_d;
            cbf_cnt_q    <= cbf_cnt_d;
            step_q       <= step_d;
        end
    end

    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_Cin    = alu_cin_q;
    assign alu_Mode   = alu_mode_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign result     = result_q;
    assign result_cbf = result_cbf_q;
    assign cbf_count  = cbf_cnt_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench with registered adder accumulator stubs
module tb_alu_op_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = '0;
    logic [10:0] prog_data = '0;
    logic [3:0]  Seed = '0;
    logic        Start = 1'b0;
    logic [3:0]  acc_Y = '0;
    logic        acc_CBF = 1'b0;
    logic [3:0]  alu_A, alu_B, alu_Mode, result;
    logic        alu_Cin, Busy, Done, result_cbf;
    logic [3:0]  cbf_count, step_count;

    logic        p2_we = 1'b0;
    logic [2:0]  p2_addr = '0;
    logic [10:0] p2_data = '0;
    logic [3:0]  p2_seed = '0;
    logic        p2_start = 1'b0;
    logic [3:0]  p2_acc_y = '0;
    logic        p2_acc_cbf = 1'b0;
    logic [3:0]  p2_a, p2_b, p2_mode, p2_result;
    logic        p2_cin, p2_busy, p2_done, p2_result_cbf;
    logic [1:0]  p2_cbf_count;
    logic [3:0]  p2_step_count;

    int total = 0;
    int bad = 0;
    int oa[8], ob[8], oc[8];
    int dc;

    always #5 Clk = ~Clk;

    alu_op_sequencer #(.WAIT_CYC(1), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .Seed(Seed), .Start(Start), .acc_Y(acc_Y), .acc_CBF(acc_CBF),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_Mode(alu_Mode),
        .Busy(Busy), .Done(Done), .result(result), .result_cbf(result_cbf),
        .cbf_count(cbf_count), .step_count(step_count)
    );

    alu_op_sequencer #(.WAIT_CYC(1), .CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .prog_we(p2_we), .prog_addr(p2_addr), .prog_data(p2_data),
        .Seed(p2_seed), .Start(p2_start), .acc_Y(p2_acc_y), .acc_CBF(p2_acc_cbf),
        .alu_A(p2_a), .alu_B(p2_b), .alu_Cin(p2_cin), .alu_Mode(p2_mode),
        .Busy(p2_busy), .Done(p2_done), .result(p2_result), .result_cbf(p2_result_cbf),
        .cbf_count(p2_cbf_count), .step_count(p2_step_count)
    );

    always_ff @(posedge Clk) begin
        {acc_CBF, acc_Y} <= (alu_Mode == 4'd0) ? (5'(alu_A) + 5'(alu_B) + 5'(alu_Cin)) : 5'd0;
        {p2_acc_cbf, p2_acc_y} <= (p2_mode == 4'd0) ? (5'(p2_a) + 5'(p2_b) + 5'(p2_cin)) : 5'd0;
    end

    function automatic logic [10:0] enc(input logic l, input logic u, input logic c,
                                        input logic [3:0] b, input logic [3:0] m);
        return {l, u, c, b, m};
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [10:0] d);
        @(negedge Clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge Clk);
        prog_we = 1'b0;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [10:0] d);
        @(negedge Clk);
        p2_we = 1'b1; p2_addr = a; p2_data = d;
        @(negedge Clk);
        p2_we = 1'b0;
    endtask

    // k counts rising edges after the Start edge; outputs are sampled 1 time unit after each.
    task automatic run(input logic [3:0] s, input int inj, input int rst_at, output int done_at);
        done_at = -1;
        @(negedge Clk);
        Seed = s; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; prog_we = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clk); #1;
            if ((k % 3 == 1) && (k / 3 < 8)) begin
                oa[k/3] = alu_A; ob[k/3] = alu_B; oc[k/3] = alu_Cin;
            end
            if (k == 1) chk("busy_running", Busy, 1);
            if (done_at > 0 && k == done_at + 1) begin
                chk("done_one_cycle", Done, 0);
                chk("busy_after_done", Busy, 0);
                break;
            end
            if (Done && done_at < 0) done_at = k;
            if (k == inj) begin
                Start = 1'b1; prog_we = 1'b1; prog_addr = 3'd0; prog_data = enc(1, 0, 0, 4'h0, 4'h0);
            end
            if (k == inj + 1) begin
                Start = 1'b0; prog_we = 1'b0;
            end
            if (k == rst_at) begin
                Reset = 1'b1;
                #1;
                chk("rst_busy", Busy, 0);
                chk("rst_alu_a", alu_A, 0);
                chk("rst_alu_b", alu_B, 0);
                chk("rst_result", result, 0);
                chk("rst_step", step_count, 0);
                chk("rst_done", Done, 0);
                #3;
                Reset = 1'b0;
            end
        end
    endtask

    initial begin
        #12;
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_alu_a", alu_A, 0);
        chk("reset_alu_b", alu_B, 0);
        chk("reset_alu_cin", alu_Cin, 0);
        chk("reset_alu_mode", alu_Mode, 0);
        chk("reset_result", result, 0);
        chk("reset_result_cbf", result_cbf, 0);
        chk("reset_cbf_count", cbf_count, 0);
        chk("reset_step_count", step_count, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Two-step chain: 3+4=7, then 7+2+1=10
        wr(3'd0, enc(0, 0, 0, 4'h4, 4'h0));
        wr(3'd1, enc(1, 1, 1, 4'h2, 4'h0));
        run(4'h3, -1, -1, dc);
        chk("chain_done_at", dc, 7);
        chk("chain_a0", oa[0], 3);
        chk("chain_b0", ob[0], 4);
        chk("chain_c0", oc[0], 0);
        chk("chain_a1", oa[1], 7);
        chk("chain_b1", ob[1], 2);
        chk("chain_c1", oc[1], 1);
        chk("chain_result", result, 10);
        chk("chain_cbf", result_cbf, 0);
        chk("chain_cbf_count", cbf_count, 0);
        chk("chain_steps", step_count, 2);

        // Start and prog_we during a run are ignored
        run(4'h3, 1, -1, dc);
        chk("busy_ign_done_at", dc, 7);
        chk("busy_ign_result", result, 10);
        chk("busy_ign_steps", step_count, 2);
        run(4'h3, -1, -1, dc);
        chk("mem_kept_result", result, 10);
        chk("mem_kept_steps", step_count, 2);

        // Reset during step 1 WAIT aborts without Done, then a rerun works
        run(4'h3, -1, 4, dc);
        chk("rst_no_done", dc, -1);
        run(4'h3, -1, -1, dc);
        chk("rerun_done_at", dc, 7);
        chk("rerun_result", result, 10);
        chk("rerun_steps", step_count, 2);

        // Overflow: F+F+1 = 1F
        wr(3'd0, enc(1, 0, 1, 4'hF, 4'h0));
        run(4'hF, -1, -1, dc);
        chk("ovf_done_at", dc, 4);
        chk("ovf_result", result, 15);
        chk("ovf_cbf", result_cbf, 1);
        chk("ovf_cbf_count", cbf_count, 1);
        chk("ovf_steps", step_count, 1);

        // No last bit anywhere: runs all 8 entries
        for (int i = 0; i < 8; i++) wr(3'(i), enc(0, 1, 0, 4'h1, 4'h0));
        run(4'h0, -1, -1, dc);
        chk("full_done_at", dc, 25);
        chk("full_result", result, 8);
        chk("full_steps", step_count, 8);
        chk("full_cbf_count", cbf_count, 0);
        chk("full_a7", oa[7], 7);

        // Write and Start in the same idle cycle: the new entry is used
        @(negedge Clk);
        prog_we = 1'b1; prog_addr = 3'd0; prog_data = enc(1, 0, 0, 4'h5, 4'h0);
        run(4'h2, -1, -1, dc);
        chk("wr_start_done_at", dc, 4);
        chk("wr_start_a0", oa[0], 2);
        chk("wr_start_result", result, 7);
        chk("wr_start_steps", step_count, 1);

        // Saturating counter at CNT_W=2 with four overflowing steps
        for (int i = 0; i < 4; i++) wr2(3'(i), enc(i == 3, 1, 1, 4'hF, 4'h0));
        @(negedge Clk);
        p2_seed = 4'hF; p2_start = 1'b1;
        @(negedge Clk);
        p2_start = 1'b0;
        dc = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge Clk); #1;
            if (p2_done) begin
                dc = k;
                break;
            end
        end
        chk("sat_done_seen", (dc >= 0) ? 1 : 0, 1);
        chk("sat_cbf_count", p2_cbf_count, 3);
        chk("sat_steps", p2_step_count, 4);
        chk("sat_result", p2_result, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
